// File: rtl/display_pkg.sv
// +----------------------------------------------------------------------------+
// | display_pkg: shared digit-code alphabet, display limit and converter state.  |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

package display_pkg;

  localparam logic [3:0] DIG_BLANK   = 4'd10;
  localparam logic [3:0] DIG_E       = 4'd11;
  localparam logic [3:0] DIG_R       = 4'd12;
  localparam int         MAX_DISPLAY = 999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } score_state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_add3.sv
// +----------------------------------------------------------------------------+
// | bcd_add3: double-dabble nibble correction, adds 3 when the nibble is >= 5.   |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module bcd_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;

endmodule

`default_nettype wire

// File: rtl/score_digits.sv
// +----------------------------------------------------------------------------+
// | score_digits: iterative binary-to-BCD converter driving three digit codes.   |
// | Option macro: SCORE_LEAD_ZERO_BLANK_EN (blank leading zeros).                |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module score_digits #(
  parameter int WIDTH = 10
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             START,
  input  logic [WIDTH-1:0] VALUE,
  output logic             BUSY,
  output logic             DONE,
  output logic [3:0]       DIG2,
  output logic [3:0]       DIG1,
  output logic [3:0]       DIG0
);

  import display_pkg::*;

  localparam int               c_cnt_w = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);
`ifdef SCORE_LEAD_ZERO_BLANK_EN
  localparam logic [3:0]       c_rst_hi = DIG_BLANK;
`else
  localparam logic [3:0]       c_rst_hi = 4'd0;
`endif

  score_state_t       r_state;
  logic [WIDTH-1:0]   r_bin;
  logic [11:0]        r_bcd;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_ovf;
  logic [11:0]        w_adj;
  logic [3:0]         w_dig2;
  logic [3:0]         w_dig1;
  logic [3:0]         w_dig0;

  for (genvar i = 0; i < 3; i++) begin : g_nib
    bcd_add3 u_add3 (
      .i_nib (r_bcd[4*i +: 4]),
      .o_nib (w_adj[4*i +: 4])
    );
  end

  always_comb begin
    w_dig2 = r_bcd[11:8];
    w_dig1 = r_bcd[7:4];
    w_dig0 = r_bcd[3:0];
`ifdef SCORE_LEAD_ZERO_BLANK_EN
    if (r_bcd[11:8] == 4'd0) w_dig2 = DIG_BLANK;
    if (r_bcd[11:4] == 8'd0) w_dig1 = DIG_BLANK;
`endif
    // Overflow wins over digit formatting; hundreds carry is meaningless then.
    if (r_ovf) begin
      w_dig2 = DIG_E;
      w_dig1 = DIG_R;
      w_dig0 = DIG_R;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      DIG2    <= c_rst_hi;
      DIG1    <= c_rst_hi;
      DIG0    <= 4'd0;
    end else begin
      DONE <= 1'b0;
      case (r_state)
        IDLE: begin
          if (START) begin
            r_bin   <= VALUE;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_ovf   <= (32'(VALUE) > MAX_DISPLAY);
            BUSY    <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd <= {w_adj[10:0], r_bin[WIDTH-1]};
          r_bin <= {r_bin[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) r_state <= FINISH;
        end
        FINISH: begin
          DIG2    <= w_dig2;
          DIG1    <= w_dig1;
          DIG0    <= w_dig0;
          DONE    <= 1'b1;
          BUSY    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_score_digits.sv
// +----------------------------------------------------------------------------+
// | tb_score_digits: directed self-checking bench for score_digits (WIDTH=10).   |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_score_digits;

`ifdef SCORE_LEAD_ZERO_BLANK_EN
  localparam int Z = 10;
`else
  localparam int Z = 0;
`endif

  logic       CLK = 1'b0;
  logic       RESETN;
  logic       START;
  logic [9:0] VALUE;
  logic       BUSY;
  logic       DONE;
  logic [3:0] DIG2;
  logic [3:0] DIG1;
  logic [3:0] DIG0;

  int n_chk  = 0;
  int n_pass = 0;

  score_digits #(.WIDTH(10)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .START  (START),
    .VALUE  (VALUE),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .DIG2   (DIG2),
    .DIG1   (DIG1),
    .DIG0   (DIG0)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_digits(input string tag, input int e2, input int e1, input int e0);
    chk({tag, ".dig2"}, int'(DIG2), e2);
    chk({tag, ".dig1"}, int'(DIG1), e1);
    chk({tag, ".dig0"}, int'(DIG0), e0);
  endtask

  // One full conversion: checks busy, latency, digits and the one-cycle done.
  task automatic conv(input string tag, input int v, input int e2, input int e1, input int e0);
    int n;
    @(negedge CLK);
    START = 1'b1;
    VALUE = 10'(v);
    @(posedge CLK);
    #1;
    START = 1'b0;
    VALUE = 10'($urandom);
    chk({tag, ".busy"}, int'(BUSY), 1);
    n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
    end while (!DONE && n < 20);
    chk({tag, ".latency"}, n, 11);
    chk_digits(tag, e2, e1, e0);
    chk({tag, ".busy_end"}, int'(BUSY), 0);
    @(posedge CLK);
    #1;
    chk({tag, ".done_1cyc"}, int'(DONE), 0);
  endtask

  initial begin
    int ndone;
    int t[3];
    int cyc;
    int n;

    RESETN = 1'b0;
    START  = 1'b0;
    VALUE  = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk_digits("reset", Z, Z, 0);
    chk("reset.busy", int'(BUSY), 0);
    chk("reset.done", int'(DONE), 0);
    @(negedge CLK);
    RESETN = 1'b1;
    @(posedge CLK);
    #1;
    chk_digits("post_reset", Z, Z, 0);
    chk("post_reset.busy", int'(BUSY), 0);

    conv("v437",  437,  4,  3, 7);
    conv("v5",    5,    Z,  Z, 5);
    conv("v60",   60,   Z,  6, 0);
    conv("v0",    0,    Z,  Z, 0);
    conv("v999",  999,  9,  9, 9);
    conv("v1000", 1000, 11, 12, 12);
    conv("v1023", 1023, 11, 12, 12);
    conv("v999b", 999,  9,  9, 9);

    // Second START three cycles into a conversion must be ignored.
    @(negedge CLK);
    START = 1'b1;
    VALUE = 10'd123;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    START = 1'b1;
    VALUE = 10'd456;
    @(posedge CLK);
    #1;
    START = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK);
      #1;
      if (DONE) begin
        ndone++;
        if (ndone == 1) chk_digits("busy_ign", 1, 2, 3);
      end
    end
    chk("busy_ign.ndone", ndone, 1);

    // START held high: a conversion every WIDTH+2 cycles.
    @(negedge CLK);
    START = 1'b1;
    VALUE = 10'd42;
    ndone = 0;
    cyc = 0;
    while (ndone < 3 && cyc < 60) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (DONE) begin
        t[ndone] = cyc;
        ndone++;
      end
    end
    chk("held.ndone", ndone, 3);
    chk("held.period1", t[1] - t[0], 12);
    chk("held.period2", t[2] - t[1], 12);
    chk_digits("held", Z, 4, 2);
    START = 1'b0;
    n = 0;
    while (BUSY && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("held.drain", int'(BUSY), 0);
    @(posedge CLK);
    #1;

    // Asynchronous reset in the middle of a conversion of 888.
    @(negedge CLK);
    START = 1'b1;
    VALUE = 10'd888;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    RESETN = 1'b0;
    #1;
    chk_digits("async_rst", Z, Z, 0);
    chk("async_rst.busy", int'(BUSY), 0);
    @(negedge CLK);
    RESETN = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      #1;
      if (DONE) ndone++;
    end
    chk("async_rst.no_done", ndone, 0);
    chk_digits("async_rst.after", Z, Z, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
